// File: rtl/lu_result_buffer.sv
// rtl/lu_result_buffer.sv - two-entry registered result/flag buffer behind the logic unit
module lu_result_buffer #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_za,
   input  logic              in_zb,
   input  logic              in_eq,
   input  logic              in_gt,
   input  logic              in_lt,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [4:0]        out_flags,
   output logic [TAG_W-1:0]  out_tag,
   output logic [4:0]        flags_q,
   output logic [1:0]        count,
   output logic [CNT_W-1:0]  commit_cnt
);

   logic [DATA_W-1:0] r_h_result;
   logic [4:0]        r_h_flags;
   logic [TAG_W-1:0]  r_h_tag;
   logic [DATA_W-1:0] r_t_result;
   logic [4:0]        r_t_flags;
   logic [TAG_W-1:0]  r_t_tag;
   logic [1:0]        r_count;
   logic [4:0]        r_flags_q;
   logic [CNT_W-1:0]  r_commit_cnt;

   logic [4:0]        w_in_flags;
   logic              w_push;
   logic              w_pop;

   assign w_in_flags = {in_lt, in_gt, in_eq, in_zb, in_za};

   // in_ready deliberately ignores out_ready so no combinational path crosses the stage
   assign in_ready  = (r_count != 2'd2) & ~flush;
   assign out_valid = (r_count != 2'd0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready & ~flush;

   assign out_result = r_h_result;
   assign out_flags  = r_h_flags;
   assign out_tag    = r_h_tag;
   assign flags_q    = r_flags_q;
   assign count      = r_count;
   assign commit_cnt = r_commit_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_h_result   <= '0;
         r_h_flags    <= '0;
         r_h_tag      <= '0;
         r_t_result   <= '0;
         r_t_flags    <= '0;
         r_t_tag      <= '0;
         r_count      <= 2'd0;
         r_flags_q    <= '0;
         r_commit_cnt <= '0;
      end else if (flush) begin
         r_count <= 2'd0;
      end else begin
         if (w_pop) begin
            r_flags_q    <= r_h_flags;
            r_commit_cnt <= r_commit_cnt + CNT_W'(1);
         end
         case (r_count)
            2'd0: begin
               if (w_push) begin
                  r_h_result <= in_result;
                  r_h_flags  <= w_in_flags;
                  r_h_tag    <= in_tag;
                  r_count    <= 2'd1;
               end
            end
            2'd1: begin
               if (w_push && w_pop) begin
                  r_h_result <= in_result;
                  r_h_flags  <= w_in_flags;
                  r_h_tag    <= in_tag;
               end else if (w_push) begin
                  r_t_result <= in_result;
                  r_t_flags  <= w_in_flags;
                  r_t_tag    <= in_tag;
                  r_count    <= 2'd2;
               end else if (w_pop) begin
                  r_count <= 2'd0;
               end
            end
            2'd2: begin
               // full: no push is possible, a pop just advances the tail
               if (w_pop) begin
                  r_h_result <= r_t_result;
                  r_h_flags  <= r_t_flags;
                  r_h_tag    <= r_t_tag;
                  r_count    <= 2'd1;
               end
            end
            default: r_count <= 2'd0;
         endcase
      end
   end

endmodule
